// File: rtl/ccg_pkg.sv
// Shared types and constants for the programmable LUT sweeper.
package ccg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } ccg_state_e;

  localparam logic [31:0] CCG_DEFAULT_POLY = 32'h04C11DB7;
  localparam int unsigned CCG_MAX_IN       = 8;

  // Row-address width; keeps a 1-bit port when only one output exists.
  function automatic int unsigned ccg_addr_w(input int unsigned n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

endpackage

// File: rtl/ccg_lut_sweeper_if.sv
// Config, eval and sweep-control signals of ccg_lut_sweeper.
interface ccg_lut_sweeper_if
  import ccg_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 20,
  parameter int unsigned SIG_W = 32
);
  localparam int unsigned AW   = ccg_addr_w(N_OUT);
  localparam int unsigned ROWS = 1 << N_IN;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [AW-1:0]     cfg_addr;
  logic [ROWS-1:0]   cfg_data;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_x;
  logic              out_valid;
  logic              out_ready;
  logic [N_OUT-1:0]  out_f;
  logic              start;
  logic              busy;
  logic              done;
  logic [SIG_W-1:0]  signature;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, in_valid, in_x, out_ready, start,
    input  cfg_ready, in_ready, out_valid, out_f, busy, done, signature
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, in_valid, in_x, out_ready, start,
    output cfg_ready, in_ready, out_valid, out_f, busy, done, signature
  );

endinterface

// File: rtl/ccg_misr.sv
// Multiple-input signature register: shift, fold POLY on MSB carry-out, xor in d.
module ccg_misr
  import ccg_pkg::*;
#(
  parameter int unsigned      SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(CCG_DEFAULT_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] d,
  output logic [SIG_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q << 1) ^ (q[SIG_W-1] ? POLY : '0) ^ d;
    end
  end

endmodule

// File: rtl/ccg_lut_sweeper.sv
// Flop-based N_IN x N_OUT truth table with a registered eval stage and a MISR sweep.
module ccg_lut_sweeper
  import ccg_pkg::*;
#(
  parameter int unsigned      N_IN  = 4,
  parameter int unsigned      N_OUT = 20,
  parameter int unsigned      SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(CCG_DEFAULT_POLY)
) (
  input logic               clk,
  input logic               rst,
  ccg_lut_sweeper_if.slave  bus
);

  localparam int unsigned AW   = ccg_addr_w(N_OUT);
  localparam int unsigned ROWS = 1 << N_IN;

  ccg_state_e        state;
  logic [N_IN-1:0]   cnt;
  logic [ROWS-1:0]   tbl [N_OUT];
  logic [N_OUT-1:0]  eval_f;
  logic [N_OUT-1:0]  sweep_f;
  logic              busy_q;
  logic              done_q;
  logic              out_valid_q;
  logic [N_OUT-1:0]  out_f_q;
  logic [SIG_W-1:0]  sig;

  logic idle;
  logic start_acc;
  logic cfg_acc;
  logic in_acc;

  // start wins over config and eval in the same IDLE cycle.
  assign idle      = (state == IDLE);
  assign start_acc = idle & bus.start;
  assign cfg_acc   = idle & ~bus.start & bus.cfg_valid;
  assign in_acc    = idle & ~bus.start & bus.in_valid & (~out_valid_q | bus.out_ready);

  assign bus.cfg_ready = idle & ~bus.start;
  assign bus.in_ready  = idle & ~bus.start & (~out_valid_q | bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_f     = out_f_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.signature = sig;

  // Two independent read ports: one indexed by the eval vector, one by the sweep counter.
  always_comb begin
    eval_f  = '0;
    sweep_f = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      eval_f[j]  = tbl[j][bus.in_x];
      sweep_f[j] = tbl[j][cnt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < N_OUT; j++) begin
        tbl[j] <= '0;
      end
    end else begin
      // Addresses at or above N_OUT match no row and are dropped.
      for (int unsigned j = 0; j < N_OUT; j++) begin
        if (cfg_acc && (bus.cfg_addr == AW'(j))) begin
          tbl[j] <= bus.cfg_data;
        end
      end
    end
  end

  // busy/done are registered from the state, so they trail it by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state == SWEEP);
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= SWEEP;
            cnt   <= '0;
          end
        end
        SWEEP: begin
          cnt <= cnt + N_IN'(1);
          if (cnt == '1) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
    end else if (in_acc) begin
      out_valid_q <= 1'b1;
      out_f_q     <= eval_f;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  ccg_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .en  (state == SWEEP),
    .d   (SIG_W'(sweep_f)),
    .q   (sig)
  );

endmodule

// File: tb/tb_ccg_lut_sweeper.sv
// Directed bench for ccg_lut_sweeper with a transaction-level reference model.
module tb_ccg_lut_sweeper;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ccg_lut_sweeper_if #(.N_IN(4), .N_OUT(20), .SIG_W(32)) bus ();

  ccg_lut_sweeper #(
    .N_IN  (4),
    .N_OUT (20),
    .SIG_W (32),
    .POLY  (POLY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_since: cycles since an accepted start (-1 = no sweep in flight).
  logic [15:0] m_tbl [20];
  int          m_since = -1;
  bit          m_swept = 1'b0;
  logic [31:0] m_sig   = '0;
  bit          m_ov    = 1'b0;
  logic [19:0] m_of    = '0;

  function automatic logic [19:0] mf(input logic [3:0] x);
    logic [19:0] r;
    for (int j = 0; j < 20; j++) r[j] = m_tbl[j][x];
    return r;
  endfunction

  function automatic logic [31:0] msweep();
    logic [31:0] s = '0;
    for (int i = 0; i < 16; i++)
      s = (s << 1) ^ (s[31] ? POLY : 32'h0) ^ {12'h0, mf(4'(i))};
    return s;
  endfunction

  function automatic bit m_idle();
    return (m_since < 0) || (m_since == 17);
  endfunction

  always @(posedge clk or posedge rst) begin
    bit idl, st_acc, cfg_acc, in_acc;
    if (rst) begin
      for (int j = 0; j < 20; j++) m_tbl[j] = '0;
      m_since = -1;
      m_swept = 1'b0;
      m_sig   = '0;
      m_ov    = 1'b0;
      m_of    = '0;
    end else begin
      idl     = m_idle();
      st_acc  = idl && bus.start;
      cfg_acc = idl && !bus.start && bus.cfg_valid;
      in_acc  = idl && !bus.start && bus.in_valid && (!m_ov || bus.out_ready);
      if (st_acc) begin
        m_since = 0;
        m_sig   = msweep();
        m_swept = 1'b1;
      end else if (m_since >= 0) begin
        m_since = (m_since == 17) ? -1 : m_since + 1;
      end
      if (in_acc) begin
        m_of = mf(bus.in_x);
        m_ov = 1'b1;
      end else if (bus.out_ready) begin
        m_ov = 1'b0;
      end
      if (cfg_acc && (int'(bus.cfg_addr) < 20)) m_tbl[int'(bus.cfg_addr)] = bus.cfg_data;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit idl;
    if (rst === 1'b1) begin
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_sig", 64'(bus.signature), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    end else if (rst === 1'b0) begin
      idl = m_idle();
      chk("busy", 64'(bus.busy), 64'(m_since >= 1 && m_since <= 16));
      chk("done", 64'(bus.done), 64'(m_since == 17));
      chk("cfg_ready", 64'(bus.cfg_ready), 64'(idl && !bus.start));
      chk("in_ready", 64'(bus.in_ready), 64'(idl && !bus.start && (!m_ov || bus.out_ready)));
      chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
      if (m_ov) chk("out_f", 64'(bus.out_f), 64'(m_of));
      if (m_since == 17) chk("sig_done", 64'(bus.signature), 64'(m_sig));
      else if (idl) chk("sig_idle", 64'(bus.signature), m_swept ? 64'(m_sig) : 64'd0);
    end
  end

  // ---------------- stimulus helpers (enter/leave #1 after a rising edge) ----------------
  task automatic cfg_write(input int a, input logic [15:0] d);
    bit ok = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 5'(a);
    bus.cfg_data  = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      ok = bus.cfg_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    bus.cfg_valid = 1'b0;
    if (!ok) chk("cfg_write_timeout", 64'd0, 64'd1);
  endtask

  task automatic eval(input logic [3:0] x, output logic [19:0] f);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("eval_timeout", 64'd0, 64'd1);
    @(negedge clk);
    f = bus.out_f;
    @(posedge clk); #1;
  endtask

  task automatic do_sweep(output int bc, output int dn);
    bc = 0;
    dn = -1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.done) begin
        dn = n;
        break;
      end
    end
    if (dn < 0) chk("sweep_done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] f;
    int bc, dn, cr, dcnt;

    rst           = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.out_ready = 1'b1;
    bus.start     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_sig", 64'(bus.signature), 64'd0);
    chk("post_rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    @(posedge clk); #1;

    // empty table sweep: 16 busy cycles, done on the 17th, signature 0
    do_sweep(bc, dn);
    chk("empty_busy_cycles", 64'(bc), 64'd16);
    chk("empty_done_cycle", 64'(dn), 64'd17);
    chk("empty_sig", 64'(bus.signature), 64'd0);

    // f1 = x0
    cfg_write(0, 16'hAAAA);
    eval(4'b0001, f);
    chk("eval_x1", 64'(f), 64'h00001);
    eval(4'b0010, f);
    chk("eval_x2", 64'(f), 64'h00000);
    do_sweep(bc, dn);
    chk("x0_sig", 64'(bus.signature), 64'h00005555);

    // single MSB carry-out exercises the polynomial feedback
    cfg_write(0, 16'h0000);
    cfg_write(19, 16'h0001);
    do_sweep(bc, dn);
    chk("poly_sig", 64'(bus.signature), 64'h130476DC);
    chk("poly_done_cycle", 64'(dn), 64'd17);

    // random table, out-of-range write dropped
    for (int j = 0; j < 20; j++) cfg_write(j, 16'($urandom));
    cfg_write(25, 16'hFFFF);
    cfg_write(31, 16'hFFFF);
    do_sweep(bc, dn);
    chk("rand_sig", 64'(bus.signature), 64'(msweep()));
    bus.in_valid = 1'b1;
    for (int x = 0; x < 16; x++) begin
      bus.in_x = 4'(x);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // backpressure then back-to-back accept
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_x      = 4'd3;
    @(posedge clk); #1;
    bus.in_x = 4'd5;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_f_hold", 64'(bus.out_f), 64'(mf(4'd3)));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_next_f", 64'(bus.out_f), 64'(mf(4'd5)));
    @(posedge clk); #1;

    // a pending result survives a sweep
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_x      = 4'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    do_sweep(bc, dn);
    chk("pend_valid", 64'(bus.out_valid), 64'd1);
    chk("pend_f", 64'(bus.out_f), 64'(mf(4'd7)));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    // start beats cfg; second start ignored; cfg lands once IDLE again
    bus.start     = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 5'd2;
    bus.cfg_data  = 16'h1234;
    @(negedge clk);
    chk("start_blocks_cfg", 64'(bus.cfg_ready), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    dn = -1;
    cr = -1;
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      if (bus.done && dn < 0) dn = n;
      if (bus.cfg_ready && cr < 0) cr = n;
      @(posedge clk); #1;
      bus.start = (n == 4);
      if (cr >= 0) break;
    end
    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
    chk("restart_done_cycle", 64'(dn), 64'd17);
    chk("cfg_ready_cycle", 64'(cr), 64'd17);
    eval(4'd2, f);
    chk("cfg_after_done_bit", 64'(f[2]), 64'd1);

    // reset at sweep cycle 8
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_sig", 64'(bus.signature), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    @(posedge clk); #1;
    cfg_write(0, 16'hAAAA);
    do_sweep(bc, dn);
    chk("resweep_sig", 64'(bus.signature), 64'h00005555);
    chk("resweep_done_cycle", 64'(dn), 64'd17);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
